// File: rtl/ti_share_loader_pkg.sv
// Shared types and constants for the TI share loader.
// Share geometry, LFSR tap mask, FSM states.
package ti_pkg;

  localparam int SHARE_W = 8;
  localparam int NSHARES = 3;
  localparam int LFSR_W  = 16;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REFRESH
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] l
  );
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ti_share_loader_if.sv
// Share bus between the loader and the S-box core.
// Valid/ready handshake carrying {s2,s1,s0}.
import ti_pkg::*;

interface ti_share_loader_if;
  logic [SHARE_W*NSHARES-1:0] sh_out;
  logic                       sh_valid;
  logic                       sh_ready;

  modport master (
    output sh_out,
    output sh_valid,
    input  sh_ready
  );

  modport slave (
    input  sh_out,
    input  sh_valid,
    output sh_ready
  );
endinterface

// File: rtl/ti_share_loader_lfsr.sv
// 16-bit Fibonacci mask LFSR, shift left.
// An all-zero seed is replaced by SEED so the LFSR never locks up.
import ti_pkg::*;

module ti_lfsr16 #(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk) begin
    if (rst)
      state <= SEED;
    else if (load)
      state <= (seed == '0) ? SEED : seed;
    else if (step)
      state <= lfsr_next(state);
  end

endmodule

// File: rtl/ti_share_loader.sv
// Splits a plaintext byte into 3 Boolean shares for the TI S-box,
// then holds off new bytes while the masks refresh.
import ti_pkg::*;

module ti_share_loader #(
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1,
  parameter int                REFRESH_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SHARE_W-1:0]   in_data,
  input  logic                 in_load,
  output logic                 in_busy,
  input  logic                 seed_load,
  input  logic [LFSR_W-1:0]    seed_in,
  output logic                 drop_err,
  ti_share_loader_if.master    sh
);

  localparam logic [7:0] RCYC = 8'(REFRESH_CYC);

  state_t              state, state_nx;
  logic [7:0]          cnt;
  logic [LFSR_W-1:0]   lfsr;
  logic [SHARE_W-1:0]  m1, m2;
  logic                idle, capture, xfer;

  assign idle    = (state == IDLE);
  assign capture = idle && in_load && !seed_load;
  assign xfer    = (state == HOLD) && sh.sh_ready;
  assign m1      = lfsr[7:0];
  assign m2      = lfsr[15:8];

  ti_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (1'b1),
    .load  (idle && seed_load),
    .seed  (seed_in),
    .state (lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (capture)   state_nx = HOLD;
      HOLD:    if (xfer)      state_nx = REFRESH;
      REFRESH: if (cnt <= 8'd1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_busy     = !idle;
    sh.sh_valid = (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      sh.sh_out <= '0;
      drop_err  <= 1'b0;
    end else begin
      if (capture)
        sh.sh_out <= {m2, m1, in_data ^ m1 ^ m2};
      else if (xfer)
        sh.sh_out <= '0;
      if (xfer)
        cnt <= RCYC;
      else if (state == REFRESH)
        cnt <= cnt - 8'd1;
      // A strobe that cannot be captured is lost; flag it until reset.
      if (in_load && (!idle || seed_load))
        drop_err <= 1'b1;
    end
  end

endmodule
